// File: rtl/seg7_reader.sv
// seg7_reader
//
// Watches an active-low seven-segment bus and recovers the hex digit being
// shown. It is the inverse of the 4-bit-to-seven-segment display decoders and
// sits on the loopback path beside the display drivers, so a checker can
// confirm what the HEX display really shows.
//
// A new pattern must hold for STABLE_CYCLES consecutive edges before it is
// accepted. Each accepted pattern that differs from the previously accepted
// one produces exactly one event. Events land in a one-entry valid/ready
// output register. An event that arrives while that register is full and not
// being consumed is dropped, and the sticky overrun flag is set.
//
// Parameters
//   STABLE_CYCLES  edges a pattern must hold before acceptance (2..255)
//
// Ports
//   clk        rising-edge clock, the only clock
//   reset      synchronous, active-high reset
//   seg_n      segment bus, active-low, seg_n[0]=a ... seg_n[6]=g
//   out_ready  consumer accepts the output this cycle
//   out_valid  output register holds an unconsumed event
//   out_code   decoded hex digit, 0 for blank or unknown patterns
//   out_blank  event is the all-off pattern 7'h7F
//   out_err    event pattern is not a known glyph
//   overrun    sticky, an event was dropped because the output was full
//
// All outputs come straight from flops. There is no combinational path from
// seg_n to any output.

module seg7_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_n,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_code,
  output logic       out_blank,
  output logic       out_err,
  output logic       overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  // The event fires on the edge where cnt already shows STABLE_CYCLES-1
  // matching samples and the current sample is the last one needed.
  localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [6:0]    cand;
  logic [CW-1:0] cnt;
  logic [6:0]    last;

  logic [3:0]    dec_code;
  logic          dec_blank;
  logic          dec_err;
  logic          event_fire;

  // Glyph lookup for the pattern currently on the bus. It only feeds the
  // output register, so it never reaches an output port combinationally.
  always_comb begin
    dec_code  = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_n)
      7'h40:   dec_code = 4'h0;
      7'h79:   dec_code = 4'h1;
      7'h24:   dec_code = 4'h2;
      7'h30:   dec_code = 4'h3;
      7'h19:   dec_code = 4'h4;
      7'h12:   dec_code = 4'h5;
      7'h02:   dec_code = 4'h6;
      7'h78:   dec_code = 4'h7;
      7'h00:   dec_code = 4'h8;
      7'h10:   dec_code = 4'h9;
      7'h08:   dec_code = 4'hA;
      7'h03:   dec_code = 4'hB;
      7'h46:   dec_code = 4'hC;
      7'h21:   dec_code = 4'hD;
      7'h06:   dec_code = 4'hE;
      7'h0E:   dec_code = 4'hF;
      7'h7F:   dec_blank = 1'b1;
      default: dec_err   = 1'b1;
    endcase
  end

  // Comparing against last means a held pattern fires once. Because cnt
  // saturates at STABLE_CYCLES, it passes through CNT_FIRE only once per
  // candidate.
  assign event_fire = (seg_n == cand) && (cnt == CNT_FIRE) && (seg_n != last);

  // Settle filter, last-accepted tracking and the output register.
  // Reset starts with cand and last set to blank, so a blank display after
  // reset never produces an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand      <= SEG_BLANK;
      cnt       <= '0;
      last      <= SEG_BLANK;
      out_valid <= 1'b0;
      out_code  <= 4'h0;
      out_blank <= 1'b0;
      out_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (seg_n != cand) begin
        cand <= seg_n;
        cnt  <= CNT_ONE;
      end else if (cnt < CNT_SAT) begin
        cnt <= cnt + CNT_ONE;
      end

      if (event_fire) begin
        last <= seg_n;
      end

      // Priority: load (which also covers consume-and-load on the same edge),
      // then drop with overrun, then plain consume.
      if (event_fire && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_code  <= dec_code;
        out_blank <= dec_blank;
        out_err   <= dec_err;
      end else if (event_fire) begin
        overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader
//
// Directed bench for seg7_reader with STABLE_CYCLES=4. It drives segment
// patterns and handshake levels one step at a time, and compares the output
// register against hand-computed values after each step.

module tb_seg7_reader;

  logic       clk;
  logic       reset;
  logic [6:0] seg_n;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_code;
  logic       out_blank;
  logic       out_err;
  logic       overrun;

  int n_asserts = 0;
  int n_fails   = 0;

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_n     (seg_n),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_blank (out_blank),
    .out_err   (out_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge. Both
  // sampling and input changes happen there, away from the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] c,
                           input logic b, input logic e);
    check({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
    check({tag, ".code"},  {4'd0, out_code},  {4'd0, c});
    check({tag, ".blank"}, {7'd0, out_blank}, {7'd0, b});
    check({tag, ".err"},   {7'd0, out_err},   {7'd0, e});
  endtask

  initial begin
    reset     = 1'b1;
    seg_n     = 7'h7F;
    out_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    check_out("reset", 1'b0, 4'h0, 1'b0, 1'b0);
    check("reset.overrun", {7'd0, overrun}, 8'd0);

    // A blank display right after reset must stay silent.
    tick(6);
    check("blank_after_reset", {7'd0, out_valid}, 8'd0);

    // Digit 5 held for 10 edges: valid after the 4th edge, then it stays put.
    seg_n = 7'h12;
    tick(3);
    check("five_edge3", {7'd0, out_valid}, 8'd0);
    tick(1);
    check_out("five_edge4", 1'b1, 4'h5, 1'b0, 1'b0);
    tick(6);
    check_out("five_hold", 1'b1, 4'h5, 1'b0, 1'b0);
    check("five_no_second", {7'd0, overrun}, 8'd0);
    out_ready = 1'b1;
    tick(1);
    check("five_consumed", {7'd0, out_valid}, 8'd0);
    out_ready = 1'b0;

    // Glitch: 2 for 3 edges never emits, then 3 emits after its own 4 edges.
    seg_n = 7'h24;
    tick(3);
    check("glitch_two", {7'd0, out_valid}, 8'd0);
    seg_n = 7'h30;
    tick(3);
    check("three_edge3", {7'd0, out_valid}, 8'd0);
    tick(1);
    check_out("three_edge4", 1'b1, 4'h3, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick(1);
    check("three_consumed", {7'd0, out_valid}, 8'd0);
    out_ready = 1'b0;

    // Unknown pattern, then the blank pattern.
    seg_n = 7'h7E;
    tick(4);
    check_out("err_7e", 1'b1, 4'h0, 1'b0, 1'b1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    seg_n = 7'h7F;
    tick(4);
    check_out("blank_7f", 1'b1, 4'h0, 1'b1, 1'b0);
    out_ready = 1'b1;
    tick(1);
    check("blank_consumed", {7'd0, out_valid}, 8'd0);
    out_ready = 1'b0;

    // Overrun: digit 1 is held, and digit 2 is dropped.
    seg_n = 7'h79;
    tick(4);
    check_out("ovr_one", 1'b1, 4'h1, 1'b0, 1'b0);
    seg_n = 7'h24;
    tick(4);
    check_out("ovr_held", 1'b1, 4'h1, 1'b0, 1'b0);
    check("ovr_set", {7'd0, overrun}, 8'd1);
    out_ready = 1'b1;
    tick(1);
    check("ovr_consumed", {7'd0, out_valid}, 8'd0);
    check("ovr_sticky", {7'd0, overrun}, 8'd1);

    // Ready tied high: 40, 79, 40 give three one-cycle pulses.
    seg_n = 7'h40;
    tick(3);
    check("rdy_zero_edge3", {7'd0, out_valid}, 8'd0);
    tick(1);
    check_out("rdy_zero", 1'b1, 4'h0, 1'b0, 1'b0);
    seg_n = 7'h79;
    tick(1);
    check("rdy_zero_pulse", {7'd0, out_valid}, 8'd0);
    tick(2);
    check("rdy_one_edge3", {7'd0, out_valid}, 8'd0);
    tick(1);
    check_out("rdy_one", 1'b1, 4'h1, 1'b0, 1'b0);
    seg_n = 7'h40;
    tick(1);
    check("rdy_one_pulse", {7'd0, out_valid}, 8'd0);
    tick(3);
    check_out("rdy_zero_again", 1'b1, 4'h0, 1'b0, 1'b0);

    // Consume-and-load on the same edge: hold 0, then accept it exactly on the
    // edge where 1 completes.
    out_ready = 1'b0;
    seg_n = 7'h79;
    tick(3);
    check_out("cl_pending", 1'b1, 4'h0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick(1);
    check_out("cl_loaded", 1'b1, 4'h1, 1'b0, 1'b0);
    tick(1);
    check("cl_drained", {7'd0, out_valid}, 8'd0);

    // Reset while output is pending and a new pattern is mid-count.
    out_ready = 1'b0;
    seg_n = 7'h19;
    tick(4);
    check_out("rst_pending", 1'b1, 4'h4, 1'b0, 1'b0);
    seg_n = 7'h02;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_out("rst_mid", 1'b0, 4'h0, 1'b0, 1'b0);
    check("rst_mid.overrun", {7'd0, overrun}, 8'd0);
    tick(3);
    check("rst_six_edge3", {7'd0, out_valid}, 8'd0);
    tick(1);
    check_out("rst_six", 1'b1, 4'h6, 1'b0, 1'b0);
    check("rst_six.overrun", {7'd0, overrun}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
